// File: rtl/ex_mcycle_ctrl.sv
// rtl/ex_mcycle_ctrl.sv - EX-stage multi-cycle MADD/MSUB sequencer with optional restoring divider
// Define MCYC_DIV_EN to include DIV/DIVU; otherwise ops 5/6 are treated as no-ops.
module ex_mcycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  op_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic [5:0]  stall_i,
   input  logic        annul_i,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div_zero_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd3;
`ifdef MCYC_DIV_EN
   localparam logic [1:0] S_DIV  = 2'd2;
`endif

   logic [1:0]  state, state_nx;
   logic        skip;
   logic        is_mac, is_div, accept;
   logic        sub_r;
   logic [63:0] acc_r, prod_r, prod_now, mac_sum;
   logic [63:0] prod_s, prod_u;
   logic        unused_stall;

   assign unused_stall = ^{stall_i[5:3], stall_i[1:0]};

`ifdef MCYC_DIV_EN
   logic [31:0] rem_r, quo_r, dvs_r, a_mag, b_mag, rem_nx, quo_nx, q_fix, r_fix;
   logic [32:0] shl, diff;
   logic [4:0]  cnt;
   logic        neg_q, neg_r, div_signed;

   // One restoring shift-subtract step on {remainder, dividend/quotient}.
   always_comb begin
      div_signed = (op_i == 3'd5);
      a_mag = (div_signed && opdata1_i[31]) ? -opdata1_i : opdata1_i;
      b_mag = (div_signed && opdata2_i[31]) ? -opdata2_i : opdata2_i;
      shl   = {rem_r, quo_r[31]};
      diff  = shl - {1'b0, dvs_r};
      if (diff[32]) begin
         rem_nx = shl[31:0];
         quo_nx = {quo_r[30:0], 1'b0};
      end else begin
         rem_nx = diff[31:0];
         quo_nx = {quo_r[30:0], 1'b1};
      end
      q_fix = neg_q ? -quo_nx : quo_nx;
      r_fix = neg_r ? -rem_nx : rem_nx;
   end
`endif

   always_comb begin
      is_mac = (op_i >= 3'd1) && (op_i <= 3'd4);
`ifdef MCYC_DIV_EN
      is_div = (op_i == 3'd5) || (op_i == 3'd6);
`else
      is_div = 1'b0;
`endif
      accept = (state == S_IDLE) && !skip && !annul_i && (is_mac || is_div);
      stallreq_o = ((state == S_IDLE) && (is_mac || is_div) && !annul_i) || (state == S_MAC);
`ifdef MCYC_DIV_EN
      if (state == S_DIV) stallreq_o = 1'b1;
`endif
      prod_s   = $signed({{32{opdata1_i[31]}}, opdata1_i}) * $signed({{32{opdata2_i[31]}}, opdata2_i});
      prod_u   = {32'd0, opdata1_i} * {32'd0, opdata2_i};
      prod_now = (op_i == 3'd1 || op_i == 3'd3) ? prod_s : prod_u;
      mac_sum  = sub_r ? (acc_r - prod_r) : (acc_r + prod_r);
   end

   always_comb begin
      state_nx = state;
      if (annul_i) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && is_mac) state_nx = S_MAC;
`ifdef MCYC_DIV_EN
               if (accept && is_div) state_nx = (opdata2_i == 32'd0) ? S_DONE : S_DIV;
`endif
            end
            S_MAC:  state_nx = S_DONE;
`ifdef MCYC_DIV_EN
            S_DIV:  if (cnt == 5'd31) state_nx = S_DONE;
`endif
            S_DONE: if (!stall_i[2]) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         skip       <= 1'b0;
         whilo_o    <= 1'b0;
         hi_o       <= 32'd0;
         lo_o       <= 32'd0;
         div_zero_o <= 1'b0;
         sub_r      <= 1'b0;
         acc_r      <= 64'd0;
         prod_r     <= 64'd0;
`ifdef MCYC_DIV_EN
         rem_r      <= 32'd0;
         quo_r      <= 32'd0;
         dvs_r      <= 32'd0;
         cnt        <= 5'd0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         whilo_o <= (state_nx == S_DONE);
         // The IDLE cycle right after a completed op ignores op_i.
         skip    <= (state == S_DONE) && (state_nx == S_IDLE) && !annul_i;
         if (!annul_i) begin
            case (state)
               S_IDLE: if (accept) begin
                  acc_r  <= {hi_i, lo_i};
                  sub_r  <= (op_i == 3'd3) || (op_i == 3'd4);
                  prod_r <= prod_now;
`ifdef MCYC_DIV_EN
                  if (is_div) begin
                     if (opdata2_i == 32'd0) begin
                        hi_o       <= opdata1_i;
                        lo_o       <= 32'hFFFF_FFFF;
                        div_zero_o <= 1'b1;
                     end else begin
                        rem_r <= 32'd0;
                        quo_r <= a_mag;
                        dvs_r <= b_mag;
                        cnt   <= 5'd0;
                        neg_q <= div_signed && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r <= div_signed && opdata1_i[31];
                     end
                  end
`endif
               end
               S_MAC: begin
                  hi_o       <= mac_sum[63:32];
                  lo_o       <= mac_sum[31:0];
                  div_zero_o <= 1'b0;
               end
`ifdef MCYC_DIV_EN
               S_DIV: begin
                  rem_r <= rem_nx;
                  quo_r <= quo_nx;
                  cnt   <= cnt + 5'd1;
                  if (cnt == 5'd31) begin
                     hi_o       <= r_fix;
                     lo_o       <= q_fix;
                     div_zero_o <= 1'b0;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_mcycle_ctrl.sv
// tb/tb_ex_mcycle_ctrl.sv - directed table-driven bench for ex_mcycle_ctrl
// DIV vectors are exercised only when MCYC_DIV_EN is defined.
module tb_ex_mcycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  op_i;
   logic [31:0] opdata1_i, opdata2_i, hi_i, lo_i;
   logic [5:0]  stall_i;
   logic        annul_i;
   logic        stallreq_o, whilo_o, div_zero_o;
   logic [31:0] hi_o, lo_o;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo;
      logic [31:0] exp_hi, exp_lo;
      logic        exp_dz;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   ex_mcycle_ctrl dut (
      .clk(clk), .rst(rst), .op_i(op_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .hi_i(hi_i), .lo_i(lo_i), .stall_i(stall_i), .annul_i(annul_i),
      .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
      .div_zero_o(div_zero_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l);
      op_i = op; opdata1_i = a; opdata2_i = b; hi_i = h; lo_i = l;
   endtask

   task automatic run_vec(input vec_t v);
      int  cyc = 0;
      int  stl = 0;
      bit  got = 0;
      present(v.op, v.a, v.b, v.hi, v.lo);
      while (!got && cyc < 60) begin
         @(negedge clk);
         if (whilo_o) got = 1;
         else begin
            if (stallreq_o) stl++;
            tick();
            cyc++;
         end
      end
      check("latency", got ? 64'(cyc) : 64'hFFFF, 64'(v.lat));
      check("stall_cycles", 64'(stl), 64'(v.lat));
      check("hi", {32'd0, hi_o}, {32'd0, v.exp_hi});
      check("lo", {32'd0, lo_o}, {32'd0, v.exp_lo});
      check("div_zero", {63'd0, div_zero_o}, {63'd0, v.exp_dz});
      check("stallreq_in_done", {63'd0, stallreq_o}, 64'd0);
      tick();
      op_i = 3'd0;
      tick();
      tick();
   endtask

   task automatic idle_op(input logic [2:0] op);
      bit bad = 0;
      present(op, 32'd9, 32'd3, 32'd1, 32'd2);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (stallreq_o || whilo_o) bad = 1;
         tick();
      end
      check($sformatf("noop_op%0d", op), {63'd0, bad}, 64'd0);
      op_i = 3'd0;
   endtask

   initial begin
      rst = 1'b0;
      present(3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      stall_i = 6'd0;
      annul_i = 1'b0;

      vecs.push_back('{op:3'd1, a:32'hFFFFFFFE, b:32'd3, hi:32'd0, lo:32'd5,
                       exp_hi:32'hFFFFFFFF, exp_lo:32'hFFFFFFFF, exp_dz:1'b0, lat:2});
      vecs.push_back('{op:3'd4, a:32'hFFFFFFFF, b:32'd2, hi:32'd0, lo:32'hA,
                       exp_hi:32'hFFFFFFFE, exp_lo:32'h0000000C, exp_dz:1'b0, lat:2});
      vecs.push_back('{op:3'd2, a:32'hFFFFFFFF, b:32'hFFFFFFFF, hi:32'd1, lo:32'hFFFFFFFF,
                       exp_hi:32'd0, exp_lo:32'd0, exp_dz:1'b0, lat:2});
      vecs.push_back('{op:3'd3, a:32'hFFFFFFFF, b:32'hFFFFFFFF, hi:32'd0, lo:32'd0,
                       exp_hi:32'hFFFFFFFF, exp_lo:32'hFFFFFFFF, exp_dz:1'b0, lat:2});
      vecs.push_back('{op:3'd1, a:32'h80000000, b:32'h80000000, hi:32'd0, lo:32'd0,
                       exp_hi:32'h40000000, exp_lo:32'd0, exp_dz:1'b0, lat:2});
`ifdef MCYC_DIV_EN
      vecs.push_back('{op:3'd5, a:32'hFFFFFFF9, b:32'd2, hi:32'd0, lo:32'd0,
                       exp_hi:32'hFFFFFFFF, exp_lo:32'hFFFFFFFD, exp_dz:1'b0, lat:33});
      vecs.push_back('{op:3'd5, a:32'd7, b:32'hFFFFFFFE, hi:32'd0, lo:32'd0,
                       exp_hi:32'd1, exp_lo:32'hFFFFFFFD, exp_dz:1'b0, lat:33});
      vecs.push_back('{op:3'd6, a:32'd100, b:32'd0, hi:32'd0, lo:32'd0,
                       exp_hi:32'h64, exp_lo:32'hFFFFFFFF, exp_dz:1'b1, lat:1});
      vecs.push_back('{op:3'd6, a:32'd1000, b:32'd7, hi:32'd0, lo:32'd0,
                       exp_hi:32'd6, exp_lo:32'd142, exp_dz:1'b0, lat:33});
      vecs.push_back('{op:3'd6, a:32'hFFFFFFFF, b:32'd1, hi:32'd0, lo:32'd0,
                       exp_hi:32'd0, exp_lo:32'hFFFFFFFF, exp_dz:1'b0, lat:33});
      vecs.push_back('{op:3'd5, a:32'h80000000, b:32'hFFFFFFFF, hi:32'd0, lo:32'd0,
                       exp_hi:32'd0, exp_lo:32'h80000000, exp_dz:1'b0, lat:33});
      vecs.push_back('{op:3'd5, a:32'hFFFFFFFB, b:32'd0, hi:32'd0, lo:32'd0,
                       exp_hi:32'hFFFFFFFB, exp_lo:32'hFFFFFFFF, exp_dz:1'b1, lat:1});
`endif

      tick();
      tick();
      @(negedge clk);
      check("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
      check("rst_whilo", {63'd0, whilo_o}, 64'd0);
      check("rst_hi", {32'd0, hi_o}, 64'd0);
      check("rst_lo", {32'd0, lo_o}, 64'd0);
      check("rst_div_zero", {63'd0, div_zero_o}, 64'd0);
      rst = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i]);

      idle_op(3'd0);
      idle_op(3'd7);
`ifndef MCYC_DIV_EN
      idle_op(3'd5);
      idle_op(3'd6);
`endif

      // Stall hold in DONE, with op_i changed mid-hold.
      stall_i = 6'b000100;
      present(3'd1, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd5);
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("hold_whilo_%0d", k), {63'd0, whilo_o}, 64'd1);
         check($sformatf("hold_res_%0d", k), {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
         tick();
         if (k == 0) present(3'd4, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hA);
         if (k == 2) stall_i = 6'd0;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post_hold_whilo_%0d", k), {63'd0, whilo_o}, 64'd0);
         tick();
      end
      @(negedge clk);
      check("deferred_whilo", {63'd0, whilo_o}, 64'd1);
      check("deferred_res", {hi_o, lo_o}, 64'hFFFFFFFE_0000000C);
      tick();
      op_i = 3'd0;
      tick();
      tick();

      // Annul while in MAC.
      present(3'd1, 32'd3, 32'd4, 32'd0, 32'd0);
      tick();
      annul_i = 1'b1;
      op_i = 3'd0;
      @(negedge clk);
      check("annul_mac_stallreq", {63'd0, stallreq_o}, 64'd1);
      tick();
      annul_i = 1'b0;
      begin
         bit seen = 0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (whilo_o || stallreq_o) seen = 1;
            tick();
         end
         check("annul_mac_quiet", {63'd0, seen}, 64'd0);
      end

`ifdef MCYC_DIV_EN
      // Annul mid-divide.
      present(3'd6, 32'd1000, 32'd7, 32'd0, 32'd0);
      tick();
      op_i = 3'd0;
      for (int k = 1; k < 10; k++) tick();
      @(negedge clk);
      check("div_busy_stallreq", {63'd0, stallreq_o}, 64'd1);
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      begin
         bit seen = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (whilo_o || stallreq_o) seen = 1;
            tick();
         end
         check("annul_div_quiet", {63'd0, seen}, 64'd0);
      end

      // Asynchronous reset mid-divide.
      present(3'd6, 32'd1000, 32'd7, 32'd0, 32'd0);
      tick();
      op_i = 3'd0;
      for (int k = 1; k < 10; k++) tick();
      #2;
      rst = 1'b0;
      #1;
      check("rst_div_stallreq", {63'd0, stallreq_o}, 64'd0);
      check("rst_div_out", {hi_o, lo_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
`endif

      // Asynchronous reset while holding a result in DONE.
      stall_i = 6'b000100;
      present(3'd1, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd5);
      tick();
      tick();
      op_i = 3'd0;
      @(negedge clk);
      check("pre_rst_whilo", {63'd0, whilo_o}, 64'd1);
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("rst_done_whilo", {63'd0, whilo_o}, 64'd0);
      check("rst_done_out", {hi_o, lo_o}, 64'd0);
      check("rst_done_flags", {62'd0, stallreq_o, div_zero_o}, 64'd0);
      stall_i = 6'd0;
      @(negedge clk);
      rst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
